mem_access_initiator: RTL

- CPU-side initiator for the 512x8 byte RAM's MOV/MOC handshake. Accepts a SPARC op3 load/store request and checks alignment and legality.
- Translates op3 into the RAM's OP encoding. Runs one RAM transaction, or two for LDD/STD, which the RAM does not handle itself.
- Sign-extends LDSB/LDSH results and returns data or a trap to the execute stage with a done pulse.

---
 rtl/mem_access_initiator.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_initiator.sv
// CPU-side initiator for the 512x8 byte RAM MOV/MOC handshake. Decodes SPARC
// load/store op3, checks alignment, and splits LDD/STD into two RAM accesses.
module mem_access_initiator #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  op3,
    input  logic [8:0]  addr,
    input  logic [31:0] wdata_hi,
    input  logic [31:0] wdata_lo,
    output logic [31:0] rdata_hi,
    output logic [31:0] rdata_lo,
    output logic        busy,
    output logic        done,
    output logic        trap_align,
    output logic        trap_illegal,
    output logic        trap_timeout,
    output logic        mem_mov,
    output logic        mem_rw,
    output logic [8:0]  mem_addr,
    output logic [31:0] mem_din,
    output logic [5:0]  mem_op,
    input  logic        mem_moc,
    input  logic [31:0] mem_dout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS1, GAP, ACCESS2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    op3_q, op3_d;
    logic [8:0]    addr_q, addr_d;
    logic [31:0]   wlo_q, wlo_d;
    logic [31:0]   rdata_hi_q, rdata_hi_d, rdata_lo_q, rdata_lo_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          trap_align_q, trap_align_d, trap_illegal_q, trap_illegal_d;
    logic          trap_timeout_q, trap_timeout_d;
    logic          mov_q, mov_d, rw_q, rw_d;
    logic [8:0]    mem_addr_q, mem_addr_d;
    logic [31:0]   mem_din_q, mem_din_d;
    logic [5:0]    mem_op_q, mem_op_d;

    logic          legal_s, load_s, half_s, word_s, dbl_s, misalign_s;
    logic [5:0]    op_s;
    logic          is_dbl_s, is_load_s, accept_s;
    logic [31:0]   ext_s;

    function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [31:0] d);
        case (op)
            6'b001001: return {{24{d[7]}}, d[7:0]};
            6'b001010: return {{16{d[15]}}, d[15:0]};
            default:   return d;
        endcase
    endfunction

    // Decode the incoming op3 into legality, access size and RAM OP.
    always_comb begin
        legal_s = 1'b1;
        load_s  = 1'b1;
        half_s  = 1'b0;
        word_s  = 1'b0;
        dbl_s   = 1'b0;
        op_s    = 6'b000000;
        case (op3)
            6'b000000: begin word_s = 1'b1; op_s = 6'b001000; end
            6'b000001: begin op_s = 6'b000001; end
            6'b000010: begin half_s = 1'b1; op_s = 6'b000010; end
            6'b000011: begin dbl_s = 1'b1; op_s = 6'b001000; end
            6'b000100: begin load_s = 1'b0; word_s = 1'b1; op_s = 6'b000100; end
            6'b000101: begin load_s = 1'b0; op_s = 6'b000101; end
            6'b000110: begin load_s = 1'b0; half_s = 1'b1; op_s = 6'b000110; end
            6'b000111: begin load_s = 1'b0; dbl_s = 1'b1; op_s = 6'b000100; end
            6'b001001: begin op_s = 6'b000001; end
            6'b001010: begin half_s = 1'b1; op_s = 6'b000010; end
            default:   begin legal_s = 1'b0; end
        endcase
        misalign_s = (half_s & addr[0]) | (word_s & (|addr[1:0])) | (dbl_s & (|addr[2:0]));
    end

    // Only LDD/STD have op3[1:0]=11 among legal ops; stores have op3[2] set.
    assign is_dbl_s  = (op3_q[1:0] == 2'b11);
    assign is_load_s = ~op3_q[2];
    // A zero counter means MOC may be left over from the previous access.
    assign accept_s  = mem_moc & (cnt_q != {CW{1'b0}});
    assign ext_s     = load_extend(op3_q, mem_dout);

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op3_d          = op3_q;
        addr_d         = addr_q;
        wlo_d          = wlo_q;
        rdata_hi_d     = rdata_hi_q;
        rdata_lo_d     = rdata_lo_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        trap_align_d   = 1'b0;
        trap_illegal_d = 1'b0;
        trap_timeout_d = 1'b0;
        mov_d          = mov_q;
        rw_d           = rw_q;
        mem_addr_d     = mem_addr_q;
        mem_din_d      = mem_din_q;
        mem_op_d       = mem_op_q;
        case (state_q)
            IDLE: begin
                if (start && !legal_s) begin
                    done_d         = 1'b1;
                    trap_illegal_d = 1'b1;
                end else if (start && misalign_s) begin
                    done_d       = 1'b1;
                    trap_align_d = 1'b1;
                end else if (start) begin
                    state_d    = ACCESS1;
                    cnt_d      = {CW{1'b0}};
                    op3_d      = op3;
                    addr_d     = addr;
                    wlo_d      = wdata_lo;
                    busy_d     = 1'b1;
                    mov_d      = 1'b1;
                    rw_d       = load_s;
                    mem_addr_d = addr;
                    mem_op_d   = op_s;
                    mem_din_d  = wdata_hi;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS1, ACCESS2: begin
                cnt_d = cnt_q + CW'(1);
                if (accept_s) begin
                    mov_d = 1'b0;
                    if (is_load_s && state_q == ACCESS1) begin
                        rdata_hi_d = ext_s;
                    end else if (is_load_s) begin
                        rdata_lo_d = ext_s;
                    end else begin
                        rdata_hi_d = rdata_hi_q;
                    end
                    if (state_q == ACCESS1 && is_dbl_s) begin
                        state_d    = GAP;
                        mem_addr_d = addr_q + 9'd4;
                        mem_din_d  = wlo_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    mov_d          = 1'b0;
                    state_d        = IDLE;
                    done_d         = 1'b1;
                    trap_timeout_d = 1'b1;
                    busy_d         = 1'b0;
                end else begin
                    mov_d = 1'b1;
                end
            end
            GAP: begin
                state_d = ACCESS2;
                cnt_d   = {CW{1'b0}};
                mov_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
                mov_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= {CW{1'b0}};
            op3_q          <= 6'b000000;
            addr_q         <= 9'd0;
            wlo_q          <= 32'd0;
            rdata_hi_q     <= 32'd0;
            rdata_lo_q     <= 32'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            trap_align_q   <= 1'b0;
            trap_illegal_q <= 1'b0;
            trap_timeout_q <= 1'b0;
            mov_q          <= 1'b0;
            rw_q           <= 1'b0;
            mem_addr_q     <= 9'd0;
            mem_din_q      <= 32'd0;
            mem_op_q       <= 6'b000000;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op3_q          <= op3_d;
            addr_q         <= addr_d;
            wlo_q          <= wlo_d;
            rdata_hi_q     <= rdata_hi_d;
            rdata_lo_q     <= rdata_lo_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            trap_align_q   <= trap_align_d;
            trap_illegal_q <= trap_illegal_d;
            trap_timeout_q <= trap_timeout_d;
            mov_q          <= mov_d;
            rw_q           <= rw_d;
            mem_addr_q     <= mem_addr_d;
            mem_din_q      <= mem_din_d;
            mem_op_q       <= mem_op_d;
        end
    end

    assign rdata_hi     = rdata_hi_q;
    assign rdata_lo     = rdata_lo_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign trap_align   = trap_align_q;
    assign trap_illegal = trap_illegal_q;
    assign trap_timeout = trap_timeout_q;
    assign mem_mov      = mov_q;
    assign mem_rw       = rw_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;
    assign mem_op       = mem_op_q;

endmodule
